// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch and
// the LDR/STR data path, routing read data back by a latency-matched tag pipeline.
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int RAM_LAT    = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wren,
  input  logic [31:0]       ram_rdata
);

  localparam int STARVE_W = $clog2(MAX_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [RAM_LAT-1:0]  tagValid_q, tagValid_d;
  logic [RAM_LAT-1:0]  tagOwner_q, tagOwner_d;
  logic                fetchWins;

  // Data wins conflicts unless fetch has been denied MAX_STARVE cycles in a row.
  always_comb begin
    fetchWins = if_req & (~d_req | (starve_q == STARVE_MAX));
    if_gnt    = rst_n & fetchWins;
    d_gnt     = rst_n & d_req & ~fetchWins;
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    if (if_gnt) begin
      ram_addr = if_addr;
    end else if (d_gnt) begin
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
      ram_wren  = d_we;
    end
  end

  always_comb begin
    starve_d = '0;
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
    end
  end

  // Flush kills fetch tags already in flight; the tag entering stage 0 this cycle survives.
  always_comb begin
    tagValid_d    = '0;
    tagOwner_d    = '0;
    tagValid_d[0] = if_gnt | (d_gnt & ~d_we);
    tagOwner_d[0] = d_gnt;
    for (int i = 1; i < RAM_LAT; i++) begin
      tagValid_d[i] = tagValid_q[i-1] & ~(if_flush & ~tagOwner_q[i-1]);
      tagOwner_d[i] = tagOwner_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      tagValid_q <= '0;
      tagOwner_q <= '0;
    end else begin
      starve_q   <= starve_d;
      tagValid_q <= tagValid_d;
      tagOwner_q <= tagOwner_d;
    end
  end

  always_comb begin
    if_rvalid = tagValid_q[RAM_LAT-1] & ~tagOwner_q[RAM_LAT-1] & ~if_flush;
    d_rvalid  = tagValid_q[RAM_LAT-1] &  tagOwner_q[RAM_LAT-1];
    if_rdata  = ram_rdata;
    d_rdata   = ram_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 2-cycle write-first RAM
// model whose unwritten words read as 0xE0000000 + address.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_flush, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata, d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              ram_wren;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .RAM_LAT(2), .MAX_STARVE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rdata(ram_rdata)
  );

  // RAM model: write-first, data appears two cycles after the address.
  bit          wrValid [2048];
  logic [31:0] wrMem   [2048];
  logic [31:0] rdStage0, rdStage1;

  always @(posedge clk) begin
    if (ram_wren) begin
      wrValid[ram_addr] <= 1'b1;
      wrMem[ram_addr]   <= ram_wdata;
      rdStage0          <= ram_wdata;
    end else begin
      rdStage0 <= wrValid[ram_addr] ? wrMem[ram_addr] : 32'hE000_0000 + 32'(ram_addr);
    end
    rdStage1 <= rdStage0;
  end
  assign ram_rdata = rdStage1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [ADDR_W-1:0] ifAddr, input logic ifFlush,
                               input logic dReq, input logic dWe, input logic [ADDR_W-1:0] dAddr,
                               input logic [31:0] dWdata);
    if_req   = ifReq;
    if_addr  = ifAddr;
    if_flush = ifFlush;
    d_req    = dReq;
    d_we     = dWe;
    d_addr   = dAddr;
    d_wdata  = dWdata;
  endtask

  // One cycle: drive inputs just after the edge, check at the falling edge, advance.
  task automatic runCycle(input string tag,
                          input logic ifReq, input logic [ADDR_W-1:0] ifAddr, input logic ifFlush,
                          input logic dReq, input logic dWe, input logic [ADDR_W-1:0] dAddr,
                          input logic [31:0] dWdata,
                          input logic expIfGnt, input logic expDGnt,
                          input logic [ADDR_W-1:0] expRamAddr, input logic expWren,
                          input logic [31:0] expWdata,
                          input logic expIfRv, input logic expDRv, input logic [31:0] expData);
    applyStimulus(ifReq, ifAddr, ifFlush, dReq, dWe, dAddr, dWdata);
    @(negedge clk);
    checkOutput({tag, ".if_gnt"},    32'(if_gnt),    32'(expIfGnt));
    checkOutput({tag, ".d_gnt"},     32'(d_gnt),     32'(expDGnt));
    checkOutput({tag, ".ram_addr"},  32'(ram_addr),  32'(expRamAddr));
    checkOutput({tag, ".ram_wren"},  32'(ram_wren),  32'(expWren));
    checkOutput({tag, ".ram_wdata"}, ram_wdata,      expWdata);
    checkOutput({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(expIfRv));
    checkOutput({tag, ".d_rvalid"},  32'(d_rvalid),  32'(expDRv));
    if (expIfRv) checkOutput({tag, ".if_rdata"}, if_rdata, expData);
    if (expDRv)  checkOutput({tag, ".d_rdata"},  d_rdata,  expData);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input string tag, input logic expIfRv, input logic expDRv, input logic [31:0] expData);
    runCycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, expIfRv, expDRv, expData);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Grants are forced low while reset is held, even with both sides requesting.
    runCycle("rst", 1, 11'h003, 0, 1, 1, 11'h004, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idleCycle("rstRel", 0, 0, 0);
    idleCycle("rstRel2", 0, 0, 0);

    // Fetch only
    runCycle("fetch0", 1, 11'h000, 0, 0, 0, 0, 0, 1, 0, 11'h000, 0, 0, 0, 0, 0);
    runCycle("fetch1", 1, 11'h001, 0, 0, 0, 0, 0, 1, 0, 11'h001, 0, 0, 0, 0, 0);
    runCycle("fetch2", 1, 11'h002, 0, 0, 0, 0, 0, 1, 0, 11'h002, 0, 0, 1, 0, 32'hE000_0000);
    idleCycle("fetch3", 1, 0, 32'hE000_0001);
    idleCycle("fetch4", 1, 0, 32'hE000_0002);
    idleCycle("fetch5", 0, 0, 0);

    // Conflict: data first, fetch the next cycle
    runCycle("conf0", 1, 11'h007, 0, 1, 0, 11'h010, 0, 0, 1, 11'h010, 0, 0, 0, 0, 0);
    runCycle("conf1", 1, 11'h007, 0, 0, 0, 0, 0, 1, 0, 11'h007, 0, 0, 0, 0, 0);
    idleCycle("conf2", 0, 1, 32'hE000_0010);
    idleCycle("conf3", 1, 0, 32'hE000_0007);
    idleCycle("conf4", 0, 0, 0);

    // Starvation: four data grants, then fetch, then data wins again
    runCycle("starve0", 1, 11'h030, 0, 1, 0, 11'h020, 0, 0, 1, 11'h020, 0, 0, 0, 0, 0);
    runCycle("starve1", 1, 11'h030, 0, 1, 0, 11'h021, 0, 0, 1, 11'h021, 0, 0, 0, 0, 0);
    runCycle("starve2", 1, 11'h030, 0, 1, 0, 11'h022, 0, 0, 1, 11'h022, 0, 0, 0, 1, 32'hE000_0020);
    runCycle("starve3", 1, 11'h030, 0, 1, 0, 11'h023, 0, 0, 1, 11'h023, 0, 0, 0, 1, 32'hE000_0021);
    runCycle("starve4", 1, 11'h030, 0, 1, 0, 11'h024, 0, 1, 0, 11'h030, 0, 0, 0, 1, 32'hE000_0022);
    runCycle("starve5", 1, 11'h031, 0, 1, 0, 11'h024, 0, 0, 1, 11'h024, 0, 0, 0, 1, 32'hE000_0023);
    runCycle("starve6", 1, 11'h031, 0, 0, 0, 0, 0, 1, 0, 11'h031, 0, 0, 1, 0, 32'hE000_0030);
    idleCycle("starve7", 0, 1, 32'hE000_0024);
    idleCycle("starve8", 1, 0, 32'hE000_0031);
    idleCycle("starve9", 0, 0, 0);

    // Store then load of the same word
    runCycle("st", 0, 0, 0, 1, 1, 11'h005, 32'hDEAD_BEEF, 0, 1, 11'h005, 1, 32'hDEAD_BEEF, 0, 0, 0);
    runCycle("ld", 0, 0, 0, 1, 0, 11'h005, 0, 0, 1, 11'h005, 0, 0, 0, 0, 0);
    idleCycle("stld2", 0, 0, 0);
    idleCycle("stld3", 0, 1, 32'hDEAD_BEEF);
    idleCycle("stld4", 0, 0, 0);

    // Flush with three back-to-back fetches
    runCycle("flA0", 1, 11'h040, 0, 0, 0, 0, 0, 1, 0, 11'h040, 0, 0, 0, 0, 0);
    runCycle("flA1", 1, 11'h041, 0, 0, 0, 0, 0, 1, 0, 11'h041, 0, 0, 0, 0, 0);
    runCycle("flA2", 1, 11'h042, 1, 0, 0, 0, 0, 1, 0, 11'h042, 0, 0, 0, 0, 0);
    idleCycle("flA3", 0, 0, 0);
    idleCycle("flA4", 1, 0, 32'hE000_0042);
    idleCycle("flA5", 0, 0, 0);

    // Flush with a data read interleaved; the data response must survive
    runCycle("flB0", 1, 11'h050, 0, 0, 0, 0, 0, 1, 0, 11'h050, 0, 0, 0, 0, 0);
    runCycle("flB1", 0, 0, 0, 1, 0, 11'h051, 0, 0, 1, 11'h051, 0, 0, 0, 0, 0);
    runCycle("flB2", 1, 11'h052, 1, 0, 0, 0, 0, 1, 0, 11'h052, 0, 0, 0, 0, 0);
    idleCycle("flB3", 0, 1, 32'hE000_0051);
    idleCycle("flB4", 1, 0, 32'hE000_0052);
    idleCycle("flB5", 0, 0, 0);

    // Reset right after two read grants: nothing may come back
    runCycle("rm0", 1, 11'h060, 0, 0, 0, 0, 0, 1, 0, 11'h060, 0, 0, 0, 0, 0);
    runCycle("rm1", 0, 0, 0, 1, 0, 11'h061, 0, 0, 1, 11'h061, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    runCycle("rm2", 1, 11'h062, 0, 1, 1, 11'h063, 32'hCAFE_0000, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idleCycle("rm3", 0, 0, 0);
    idleCycle("rm4", 0, 0, 0);
    runCycle("rm5", 1, 11'h070, 0, 0, 0, 0, 0, 1, 0, 11'h070, 0, 0, 0, 0, 0);
    idleCycle("rm6", 0, 0, 0);
    idleCycle("rm7", 1, 0, 32'hE000_0070);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
